// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scan driver: segment patterns, blank
// code, slot phase type and the nibble decode function (SEG_HEX_EN selects hex glyphs).
package seven_seg_pkg;

  typedef enum logic {
    PH_DEAD,
    PH_LIT
  } slot_phase_e;

  // Segment order is A (bit 6) through G (bit 0); 1 = lit.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_ERR   = 7'b1001111;

  localparam logic [15:0][6:0] SEG_PATTERNS = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [6:0] seg_decode(input logic [3:0] i_Value);
`ifdef SEG_HEX_EN
    return SEG_PATTERNS[i_Value];
`else
    return (i_Value > 4'd9) ? SEG_ERR : SEG_PATTERNS[i_Value];
`endif
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 4-bit value to ABCDEFG segment decoder.
// Values 10..15 show hex glyphs when SEG_HEX_EN is defined, otherwise "E".
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_Value,
  output logic [6:0] o_Segments
);

  always_comb begin
    o_Segments = seg_decode(i_Value);
  end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver with double-buffered digits, dead time
// and frame-boundary commit. SEG_HEX_EN enables hex glyphs for values 10..15.
module seven_segment_mux
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int DEAD_CLKS      = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_L,
  input  logic [4*NUM_DIGITS-1:0] i_Digits,
  input  logic                    i_Load,
  input  logic [NUM_DIGITS-1:0]   i_Blank_Mask,
  output logic [6:0]              o_Segments,
  output logic [NUM_DIGITS-1:0]   o_Digit_En,
  output logic                    o_Frame_Done
);

  localparam int CNT_W = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW    = 4 * NUM_DIGITS;
  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0]      r_Cnt;
  logic [IDX_W-1:0]      r_Idx;
  logic [DW-1:0]         r_Pending;
  logic [DW-1:0]         r_Shadow;
  logic                  r_Pend;
  logic                  r_Frame_Wrap;

  logic                  w_Slot_End;
  logic                  w_Frame_End;
  slot_phase_e           w_Phase;
  logic [3:0]            w_Nibble;
  logic [6:0]            w_Dec_Seg;
  logic                  w_Lit;
  logic [NUM_DIGITS-1:0] w_Onehot;
  logic [NUM_DIGITS-1:0] w_En_Next;
  logic [6:0]            w_Seg_Next;

  always_comb begin
    w_Slot_End  = (r_Cnt == CNT_W'(CLKS_PER_DIGIT - 1));
    w_Frame_End = w_Slot_End && (r_Idx == IDX_W'(NUM_DIGITS - 1));
    w_Phase     = (r_Cnt < CNT_W'(DEAD_CLKS)) ? PH_DEAD : PH_LIT;
    w_Nibble    = r_Shadow[{r_Idx, 2'b00} +: 4];
    w_Onehot    = NUM_DIGITS'(1) << r_Idx;
    w_Lit       = (w_Phase == PH_LIT) && !i_Blank_Mask[r_Idx];
    w_En_Next   = w_Lit ? w_Onehot : '0;
    w_Seg_Next  = w_Lit ? w_Dec_Seg : SEG_BLANK;
  end

  seven_seg_decode u_decode (
    .i_Value    (w_Nibble),
    .o_Segments (w_Dec_Seg)
  );

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Cnt <= '0;
      r_Idx <= '0;
    end else if (w_Slot_End) begin
      r_Cnt <= '0;
      r_Idx <= w_Frame_End ? '0 : r_Idx + IDX_W'(1);
    end else begin
      r_Cnt <= r_Cnt + CNT_W'(1);
    end
  end

  // A load landing on the boundary cycle bypasses pending and wins over it.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Pending <= '0;
      r_Shadow  <= '0;
      r_Pend    <= 1'b0;
    end else begin
      if (i_Load) r_Pending <= i_Digits;
      if (w_Frame_End) begin
        if (i_Load)      r_Shadow <= i_Digits;
        else if (r_Pend) r_Shadow <= r_Pending;
        r_Pend <= 1'b0;
      end else if (i_Load) begin
        r_Pend <= 1'b1;
      end
    end
  end

  // The frame pulse lines up with the registered view of slot 0, cnt 0.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Frame_Wrap <= 1'b0;
      o_Frame_Done <= 1'b0;
      o_Digit_En   <= '0;
      o_Segments   <= SEG_BLANK ^ SEG_POL;
    end else begin
      r_Frame_Wrap <= w_Frame_End;
      o_Frame_Done <= r_Frame_Wrap;
      o_Digit_En   <= w_En_Next;
      o_Segments   <= w_Seg_Next ^ SEG_POL;
    end
  end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Scoreboard bench for seven_segment_mux (2 digits, 8 clocks/slot, 2 dead clocks).
// Expected values follow SEG_HEX_EN the same way the design build does.
module tb_seven_segment_mux;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;
`ifdef SEG_HEX_EN
  localparam logic [6:0] HA = 7'b1110111;
  localparam logic [6:0] HF = 7'b1000111;
`else
  localparam logic [6:0] HA = 7'b1001111;
  localparam logic [6:0] HF = 7'b1001111;
`endif

  logic       i_Clk = 1'b0;
  logic       i_Rst_L = 1'b0;
  logic [7:0] i_Digits = '0;
  logic       i_Load = 1'b0;
  logic [1:0] i_Blank_Mask = '0;
  logic [6:0] o_Segments;
  logic [1:0] o_Digit_En;
  logic       o_Frame_Done;

  typedef struct {
    int         cyc;
    logic [1:0] en;
    logic [6:0] seg;
    logic       fd;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  seven_segment_mux #(
    .NUM_DIGITS     (2),
    .CLKS_PER_DIGIT (8),
    .DEAD_CLKS      (2),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst_L      (i_Rst_L),
    .i_Digits     (i_Digits),
    .i_Load       (i_Load),
    .i_Blank_Mask (i_Blank_Mask),
    .o_Segments   (o_Segments),
    .o_Digit_En   (o_Digit_En),
    .o_Frame_Done (o_Frame_Done)
  );

  always #5 i_Clk = ~i_Clk;

  always @(posedge i_Clk) cyc <= cyc + 1;

  always @(negedge i_Clk) begin : monitor
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      checks++;
      if (e.cyc != cyc || o_Digit_En !== e.en || o_Segments !== e.seg ||
          o_Frame_Done !== e.fd) begin
        errors++;
        $display("FAIL %s cyc %0d: got en=%b seg=%b fd=%b, expected en=%b seg=%b fd=%b (for cyc %0d)",
                 e.tag, cyc, o_Digit_En, o_Segments, o_Frame_Done, e.en, e.seg, e.fd, e.cyc);
      end
    end
  end

  // Expect the given outputs after the next rising edge, then step past it.
  task automatic cyc_exp(input logic [1:0] en, input logic [6:0] seg,
                         input logic fd, input string tag);
    q.push_back('{cyc + 1, en, seg, fd, tag});
    @(posedge i_Clk);
    #1;
  endtask

  task automatic slot(input logic [1:0] en, input logic [6:0] seg, input logic fd,
                      input int ld_at, input logic [7:0] ld_val, input string tag);
    for (int k = 0; k < 8; k++) begin
      if (k == ld_at) begin
        i_Load   = 1'b1;
        i_Digits = ld_val;
      end
      if (k < 2) cyc_exp(2'b00, 7'b0000000, fd && (k == 0), tag);
      else       cyc_exp(en, seg, 1'b0, tag);
      i_Load = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) cyc_exp(2'b00, 7'b0000000, 1'b0, "reset");
    i_Rst_L = 1'b1;

    slot(2'b01, S0, 1'b0, 3, 8'h37, "first_d0");
    slot(2'b10, S0, 1'b0, -1, 8'h00, "first_d1");

    slot(2'b01, S7, 1'b1, -1, 8'h00, "load37_d0");
    slot(2'b10, S3, 1'b0, -1, 8'h00, "load37_d1");
    slot(2'b01, S7, 1'b1, -1, 8'h00, "hold37_d0");
    slot(2'b10, S3, 1'b0, 2, 8'hAF, "hold37_d1");

    slot(2'b01, HF, 1'b1, -1, 8'h00, "hexAF_d0");
    slot(2'b10, HA, 1'b0, -1, 8'h00, "hexAF_d1");

    i_Blank_Mask = 2'b10;
    slot(2'b01, HF, 1'b1, 4, 8'h12, "mask_d0");
    slot(2'b00, 7'b0000000, 1'b0, 3, 8'h45, "mask_d1");
    i_Blank_Mask = 2'b00;

    slot(2'b01, S5, 1'b1, 5, 8'h11, "last45_d0");
    slot(2'b10, S4, 1'b0, 7, 8'h89, "last45_d1");

    slot(2'b01, S9, 1'b1, -1, 8'h00, "bnd89_d0");
    slot(2'b10, S8, 1'b0, -1, 8'h00, "bnd89_d1");

    slot(2'b01, S9, 1'b1, 3, 8'h66, "pre_rst_d0");
    for (int k = 0; k < 5; k++) begin
      if (k < 2) cyc_exp(2'b00, 7'b0000000, 1'b0, "pre_rst_d1");
      else       cyc_exp(2'b10, S8, 1'b0, "pre_rst_d1");
    end
    i_Rst_L = 1'b0;
    cyc_exp(2'b00, 7'b0000000, 1'b0, "midrst");
    i_Rst_L = 1'b1;

    slot(2'b01, S0, 1'b0, -1, 8'h00, "post_rst_d0");
    slot(2'b10, S0, 1'b0, -1, 8'h00, "post_rst_d1");
    slot(2'b01, S0, 1'b1, -1, 8'h00, "drop66_d0");
    slot(2'b10, S0, 1'b0, -1, 8'h00, "drop66_d1");

    @(negedge i_Clk);
    @(negedge i_Clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
# seven_segment_mux

Time-multiplexed driver for a bank of NUM_DIGITS seven-segment digits sharing one segment bus. It holds a double-buffered 4-bit-per-digit value and scans digits one at a time with a programmable slot length and anti-ghosting dead time. Values are decoded to segment patterns, and new values are committed only on frame boundaries. It sits between application counters/registers and the board's segment and digit-select pins.

## Interface
- NUM_DIGITS, 2: digits scanned, legal range 1..8.
- CLKS_PER_DIGIT, 25000: clocks per digit slot, minimum 2.
- DEAD_CLKS, 250: blanked clocks at the start of each slot; must be less than CLKS_PER_DIGIT.
- SEG_ACTIVE_LOW, 0: 1 inverts o_Segments at the output register.
- i_Clk  in  1  system clock; one clock domain only.
- i_Rst_L  in  1  reset, synchronous, active-low.
- i_Digits  in  4*NUM_DIGITS  digit values; digit k is bits [4k+3:4k], and digit 0 is the rightmost.
- i_Load  in  1  strobe that captures i_Digits into the pending buffer.
- i_Blank_Mask  in  NUM_DIGITS  bit k=1 keeps digit k dark; sampled live, not buffered.
- o_Segments  out  7  bit 6 = A through bit 0 = G; 1 = lit before polarity.
- o_Digit_En  out  NUM_DIGITS  one-hot digit enable, active-high.
- o_Frame_Done  out  1  one-cycle pulse per completed frame.

## Operation
- Slot counter cnt runs 0..CLKS_PER_DIGIT-1, then wraps to 0; each wrap advances digit index idx.
- idx runs 0..NUM_DIGITS-1, then wraps to 0. The wrap from NUM_DIGITS-1 to 0 is the frame boundary.
- Pending buffer: on i_Load, pending <= i_Digits and the pend flag is set. Multiple loads within one frame: the last one wins.
- At the frame boundary with pend set: shadow <= pending and pend is cleared.
  - If i_Load is high in the boundary cycle, i_Digits goes straight to shadow and pend is cleared.
- While cnt < DEAD_CLKS: o_Digit_En = 0 and segments are blank.
- Otherwise:
  - o_Digit_En = one-hot(idx), or 0 when i_Blank_Mask[idx] is set.
  - o_Segments = decode(shadow[idx]), or blank when masked.
- Decode patterns (ABCDEFG):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - 10..15: see Configuration.
- Blank means 7'b0000000 before the polarity inversion.
- Reset values: cnt=0, idx=0, shadow=0, pending=0, pend=0, o_Digit_En=0, o_Segments=blank (all 1s if SEG_ACTIVE_LOW), o_Frame_Done=0.
- Reset asserted mid-slot or mid-frame: all state returns to reset values on the next edge, a pending load is discarded, and the scan restarts at digit 0 with a dead interval.

## Timing
- All outputs are registered with one cycle of latency from cnt/idx. The first lit cycle of a slot is the edge after cnt reaches DEAD_CLKS.
- Slot length is exactly CLKS_PER_DIGIT cycles; frame period is NUM_DIGITS*CLKS_PER_DIGIT cycles.
- o_Digit_En is never two-hot. Digit switchover always passes through at least DEAD_CLKS cycles of all-zero enable; DEAD_CLKS=0 gives direct switchover.
- o_Frame_Done is high for exactly one cycle: the cycle in which the outputs reflect the first cycle of slot 0 (the first lit cycle when DEAD_CLKS=0).
  - With NUM_DIGITS=1 it still pulses once per CLKS_PER_DIGIT cycles.
  - It does not pulse for the first slot after reset.
- From i_Load to first display: the new value appears in the frame after the next boundary, never mid-frame.
- i_Blank_Mask takes effect with one cycle of latency, independent of frames.

## Configuration
- SEG_HEX_EN defined: values 10..15 decode as A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- SEG_HEX_EN undefined: values 10..15 all decode to 1001111 ("E", error).

## Structure
- Package seven_seg_pkg holds:
  - the 16-entry segment pattern constants and the SEG_BLANK constant;
  - a decode function guarded by SEG_HEX_EN.
- Sub-module seven_seg_decode: combinational 4-bit to 7-bit decoder built on the package function. It is instantiated once, on the idx-selected nibble.
- The top level contains cnt, idx, pend/pending/shadow, and the output registers.

## Test plan
Parameters: NUM_DIGITS=2, CLKS_PER_DIGIT=8, DEAD_CLKS=2, SEG_ACTIVE_LOW=0.
- Reset check: i_Rst_L low for 3 cycles -> o_Digit_En=00, o_Segments=0000000, o_Frame_Done=0. After release, the first 2 cycles show enable 00, then 01 with segments 1111110.
- Load check: i_Load with 8'h37 -> from the following frame, each 8-cycle slot shows 2 blank cycles then:
  - digit 0: en=01, segments 1110000 for 6 cycles;
  - digit 1: en=10, segments 1111001 for 6 cycles;
  - o_Frame_Done pulses every 16 cycles.
- Hex check: load 8'hAF.
  - With SEG_HEX_EN: digit 0 shows 1000111 and digit 1 shows 1110111.
  - Without it: both digits show 1001111.
- Blank mask: i_Blank_Mask=2'b10 -> the digit 1 slot holds en=00 and segments 0000000 for all 8 cycles; digit 0 is unaffected; frame pulse cadence is unchanged.
- Last-load-wins: loads of 8'h12 then 8'h45 within one frame -> 45 is displayed and the 1/2 patterns never appear. A load in the boundary cycle is displayed in the frame that starts then.
- Mid-slot reset: reset in cnt=5 of slot 1 -> next edge gives blank outputs, the pending load is dropped and shadow=0. The scan restarts at digit 0 with 2 dead cycles.
